display_scanner: RTL and testbench

Time-multiplexed driver for the calculator's 4-digit seven-segment display. Holds a 4-digit BCD value and walks a 2-bit digit index through 0..3 at a programmable refresh rate. Drives the active-low segment pattern for the digit currently selected. `digit_sel` feeds the existing 2-to-4 active-low digit-enable decoder directly downstream, and `seg` goes to the shared cathode pins.

---
 rtl/calc_disp_pkg.sv | 22 ++
 rtl/display_scanner_seg7_encode.sv | 22 ++
 rtl/display_scanner.sv | 121 ++++++++++++
 tb/tb_display_scanner.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/calc_disp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : calc_disp_pkg
// Description : Shared types and active-low segment constants for the
//               calculator's seven-segment display path.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package calc_disp_pkg;

  // Index of one of the four display digits (0 = least significant)
  typedef logic [1:0] digit_idx_t;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage
`default_nettype wire

// File: rtl/display_scanner_seg7_encode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : seg7_encode
// Description : BCD nibble to active-low seven-segment pattern; non-BCD
//               codes (A-F) display a dash.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module seg7_encode
  import calc_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup for decimal digits, dash for anything outside 0..9
  always_comb begin
    seg = SEG_DASH;
    if (nibble <= 4'd9) seg = SEG_DIGIT[nibble];
  end

endmodule
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : display_scanner
// Description : Time-multiplexed 4-digit seven-segment driver with
//               tear-free frame-aligned value update, per-slot blanking
//               and optional leading-zero suppression.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module display_scanner
  import calc_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] value,
  input  logic        load,
  output logic [1:0]  digit_sel,
  output logic [6:0]  seg,
  output logic        frame_tick
);

  localparam int             CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  BLANK_N  = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt, cnt_nxt;
  digit_idx_t    idx, idx_nxt;
  logic [15:0]   pending, pending_nxt;
  logic          pend_valid, pend_valid_nxt;
  logic [15:0]   active, active_nxt;
  logic          boundary;
  logic [3:0]    lz_mask;
  logic [3:0]    nibble;
  logic [6:0]    enc_seg;
  logic [6:0]    seg_nxt;

  // Prescaler and digit index advance; the 3->0 index wrap marks a frame boundary
  always_comb begin
    cnt_nxt  = cnt;
    idx_nxt  = idx;
    boundary = 1'b0;
    if (en) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt  = '0;
        idx_nxt  = idx + 2'd1;
        boundary = (idx == 2'd3);
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // Shadow register for loads; the visible value only changes at a frame boundary
  always_comb begin
    pending_nxt    = load ? value : pending;
    pend_valid_nxt = load | pend_valid;
    active_nxt     = active;
    if (boundary) begin
      pend_valid_nxt = 1'b0;
      if (load)            active_nxt = value;
      else if (pend_valid) active_nxt = pending;
    end
  end

  // Leading-zero mask: digit k blanks when it and every digit above it are zero
  always_comb begin
    lz_mask    = '0;
    lz_mask[3] = (active_nxt[15:12] == 4'd0);
    lz_mask[2] = lz_mask[3] && (active_nxt[11:8] == 4'd0);
    lz_mask[1] = lz_mask[2] && (active_nxt[7:4] == 4'd0);
    if (LZ_SUPPRESS == 0) lz_mask = '0;
  end

  // Segment pattern is derived from next-state index/value so it tracks digit_sel
  always_comb begin
    nibble  = active_nxt[{idx_nxt, 2'b00} +: 4];
    seg_nxt = enc_seg;
    if (!en || (cnt_nxt < BLANK_N) || lz_mask[idx_nxt]) seg_nxt = SEG_BLANK;
  end

  seg7_encode u_encode (
    .nibble (nibble),
    .seg    (enc_seg)
  );

  // Scan, shadow and visible-value state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= 2'd0;
      pending    <= 16'h0000;
      pend_valid <= 1'b0;
      active     <= 16'h0000;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      pending    <= pending_nxt;
      pend_valid <= pend_valid_nxt;
      active     <= active_nxt;
    end
  end

  // Registered outputs, all updated on the same edge as the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel  <= 2'd0;
      seg        <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      digit_sel  <= idx_nxt;
      seg        <= seg_nxt;
      frame_tick <= boundary;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_display_scanner
// Description : Directed self-checking bench for display_scanner with
//               REFRESH_DIV=4, BLANK_CYCLES=1, LZ_SUPPRESS=1.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] value;
  logic        load;
  logic [1:0]  digit_sel;
  logic [6:0]  seg;
  logic        frame_tick;

  int compared   = 0;
  int mismatched = 0;

  display_scanner #(
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1),
    .LZ_SUPPRESS  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .value      (value),
    .load       (load),
    .digit_sel  (digit_sel),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step until frame_tick is seen, with a bounded cycle budget
  task automatic wait_frame();
    int n = 0;
    while (frame_tick !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("wait_frame", {15'd0, frame_tick}, 16'd1);
  endtask

  // Entered at a frame start; checks one full frame and ends at the next frame start.
  // Optional loads are driven before step index o1/o2 (step 15 is the boundary edge).
  task automatic check_frame(input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3,
                             input int o1, input logic [15:0] v1,
                             input int o2, input logic [15:0] v2);
    logic [6:0] exp_seg [4];
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    chk("frame_start_tick", {15'd0, frame_tick}, 16'd1);
    chk("frame_start_sel",  {14'd0, digit_sel},  16'd0);
    chk("frame_start_seg",  {9'd0, seg},         16'h7F);
    for (int i = 0; i < 16; i++) begin
      int t;
      t = i + 1;
      load  = (i == o1) || (i == o2);
      value = (i == o1) ? v1 : v2;
      step();
      load = 1'b0;
      chk($sformatf("sel t=%0d", t), {14'd0, digit_sel}, 16'((t / 4) % 4));
      if (t % 4 == 0) begin
        chk($sformatf("blank t=%0d", t), {9'd0, seg}, 16'h7F);
        chk($sformatf("tick t=%0d", t), {15'd0, frame_tick}, (t == 16) ? 16'd1 : 16'd0);
      end else begin
        chk($sformatf("seg t=%0d", t), {9'd0, seg}, {9'd0, exp_seg[t / 4]});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    value = 16'h0000;
    step();
    step();
    chk("rst_sel",  {14'd0, digit_sel},  16'd0);
    chk("rst_seg",  {9'd0, seg},         16'h7F);
    chk("rst_tick", {15'd0, frame_tick}, 16'd0);

    // Scenario 1: load 1234 and scan
    rst_n = 1'b1;
    en    = 1'b1;
    load  = 1'b1;
    value = 16'h1234;
    step();
    load  = 1'b0;
    wait_frame();
    check_frame(7'h19, 7'h30, 7'h24, 7'h79, 0, 16'h0070, -1, 16'h0000);

    // Scenario 2: leading zero suppression, then all-zero value
    check_frame(7'h40, 7'h78, 7'h7F, 7'h7F, 5, 16'h0000, -1, 16'h0000);

    // Scenario 3: two loads mid-frame, last one wins at the next boundary
    check_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 6, 16'h5555, 8, 16'h6666);
    // Load exactly on the boundary edge goes straight to the display
    check_frame(7'h02, 7'h02, 7'h02, 7'h02, 15, 16'h00A0, -1, 16'h0000);

    // Scenario 4: non-BCD nibble shows a dash; queue 1234 for the next frame
    check_frame(7'h40, 7'h3F, 7'h7F, 7'h7F, 3, 16'h1234, -1, 16'h0000);

    // Scenario 5: pause scanning in the middle of digit 2's slot
    for (int i = 0; i < 9; i++) step();
    chk("pre_pause_sel", {14'd0, digit_sel}, 16'd2);
    chk("pre_pause_seg", {9'd0, seg},        16'h24);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("pause_seg",  {9'd0, seg},         16'h7F);
      chk("pause_sel",  {14'd0, digit_sel},  16'd2);
      chk("pause_tick", {15'd0, frame_tick}, 16'd0);
    end
    en = 1'b1;
    step();
    chk("resume1_seg", {9'd0, seg},        16'h24);
    chk("resume1_sel", {14'd0, digit_sel}, 16'd2);
    step();
    chk("resume2_seg", {9'd0, seg},        16'h24);
    step();
    chk("resume3_seg", {9'd0, seg},        16'h7F);
    chk("resume3_sel", {14'd0, digit_sel}, 16'd3);
    step();
    chk("resume4_seg", {9'd0, seg},        16'h79);

    // Scenario 6: asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_seg",  {9'd0, seg},         16'h7F);
    chk("async_rst_sel",  {14'd0, digit_sel},  16'd0);
    chk("async_rst_tick", {15'd0, frame_tick}, 16'd0);
    step();
    rst_n = 1'b1;
    chk("held_rst_seg", {9'd0, seg}, 16'h7F);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_seg",  {9'd0, seg},         16'h40);
      chk("post_rst_sel",  {14'd0, digit_sel},  16'd0);
      chk("post_rst_tick", {15'd0, frame_tick}, 16'd0);
    end
    step();
    chk("post_rst_slot1_sel", {14'd0, digit_sel}, 16'd1);
    chk("post_rst_slot1_seg", {9'd0, seg},        16'h7F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
